// File: rtl/mua_pkg.sv
// rtl/mua_pkg.sv - shared types and defaults for the MUA frame reader
// Ports: none (package). Provides data width / frame size defaults,
// writer and reader state encodings, and a saturating counter helper.
package mua_pkg;

  localparam int MUA_DATA_W       = 32;
  localparam int MUA_N_CH_DEFAULT = 128;

  typedef enum logic {
    FILL,
    DROP
  } wr_state_t;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM
  } rd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mua_pingpong_ram.sv
// rtl/mua_pingpong_ram.sv - simple dual-port RAM holding both frame banks
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset (read data register only)
//   we/waddr/wdata write port
//   re/raddr       read request; rdata valid one cycle later
//   rdata          registered read data, holds its value while re=0
module mua_pingpong_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register doubles as the stream output register, so it only
  // updates on a read request; that is what keeps data stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mua_frame_reader.sv
// rtl/mua_frame_reader.sv - frames the push-only MUA stream into AXI4-Stream
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   muao_valid, muao_data    push-only input words (no backpressure)
//   m_tvalid, m_tready,
//   m_tdata, m_tlast         AXI4-Stream master, one frame of N_CH words
//   frame_cnt                frames emitted (wraps)
//   drop_cnt                 whole frames dropped (saturates)
//   overflow                 sticky drop indicator
module mua_frame_reader
  import mua_pkg::*;
#(
  parameter int N_CH   = MUA_N_CH_DEFAULT,
  parameter int DATA_W = MUA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              muao_valid,
  input  logic [DATA_W-1:0] muao_data,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              overflow
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int ADDR_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  wr_state_t        wr_state;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_bank;

  rd_state_t        rd_state;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_bank;

  logic [1:0]       bank_full;

  logic             hs;
  logic             rel;
  logic             other_free;
  logic             resume;
  logic             wr_target;
  logic             ram_we;
  logic             fill_done;

  logic             ram_re;
  logic             ram_rbank;
  logic [IDX_W-1:0] ram_ridx;
  logic [DATA_W-1:0] ram_rdata;

  assign hs  = m_tvalid && m_tready;
  assign rel = hs && m_tlast;

  // A bank released by the reader in this very cycle counts as free.
  assign other_free = !bank_full[~wr_bank] || (rel && (rd_bank == ~wr_bank));

  // While dropping, the writer parks at a frame boundary; as soon as the
  // other bank frees up it switches over, and a word arriving in that same
  // cycle is written as index 0 of the new bank so no good frame is lost.
  assign resume    = (wr_state == DROP) && (wr_idx == '0) && other_free;
  assign wr_target = resume ? ~wr_bank : wr_bank;
  assign ram_we    = muao_valid && ((wr_state == FILL) || resume);
  assign fill_done = ram_we && (wr_idx == LAST_IDX);

  // Write side
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= FILL;
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      case (wr_state)
        FILL: begin
          if (muao_valid) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              if (other_free) begin
                wr_bank <= ~wr_bank;
              end else begin
                wr_state <= DROP;
              end
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        DROP: begin
          if (resume) begin
            wr_bank  <= ~wr_bank;
            wr_state <= FILL;
            if (muao_valid) begin
              wr_idx <= IDX_W'(1);
            end
          end else if (muao_valid) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx   <= '0;
              drop_cnt <= sat_inc16(drop_cnt);
              overflow <= 1'b1;
              if (other_free) begin
                wr_bank  <= ~wr_bank;
                wr_state <= FILL;
              end
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        default: wr_state <= FILL;
      endcase
    end
  end

  // Bank ownership: writer sets on frame completion, reader clears on TLAST.
  // They never touch the same bank in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= '0;
    end else begin
      if (rel) begin
        bank_full[rd_bank] <= 1'b0;
      end
      if (fill_done) begin
        bank_full[wr_target] <= 1'b1;
      end
    end
  end

  // Read request: fetch the next word only when the current one is accepted,
  // so the RAM output register never overruns the consumer.
  always_comb begin
    ram_re    = 1'b0;
    ram_rbank = rd_bank;
    ram_ridx  = '0;
    case (rd_state)
      PREFETCH: ram_re = 1'b1;
      STREAM: begin
        if (hs) begin
          if (!m_tlast) begin
            ram_re   = 1'b1;
            ram_ridx = rd_idx + IDX_W'(1);
          end else if (bank_full[~rd_bank]) begin
            ram_re    = 1'b1;
            ram_rbank = ~rd_bank;
          end
        end
      end
      default: ;
    endcase
  end

  // Read side
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= IDLE;
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (rd_state)
        IDLE: begin
          if (bank_full[rd_bank]) begin
            rd_state <= PREFETCH;
          end
        end
        PREFETCH: begin
          rd_state <= STREAM;
          rd_idx   <= '0;
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b0;
        end
        STREAM: begin
          if (hs) begin
            if (!m_tlast) begin
              rd_idx  <= rd_idx + IDX_W'(1);
              m_tlast <= ((rd_idx + IDX_W'(1)) == LAST_IDX);
            end else begin
              frame_cnt <= frame_cnt + 32'd1;
              rd_bank   <= ~rd_bank;
              rd_idx    <= '0;
              m_tlast   <= 1'b0;
              if (!bank_full[~rd_bank]) begin
                rd_state <= IDLE;
                m_tvalid <= 1'b0;
              end
            end
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  mua_pingpong_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr ({wr_target, wr_idx}),
    .wdata (muao_data),
    .re    (ram_re),
    .raddr ({ram_rbank, ram_ridx}),
    .rdata (ram_rdata)
  );

  assign m_tdata = ram_rdata;

endmodule

// File: tb/tb_mua_frame_reader.sv
// tb/tb_mua_frame_reader.sv - self-checking bench for mua_frame_reader
module tb_mua_frame_reader;

  localparam int N_CH = 4;
  localparam int DW   = 32;

  logic          clk;
  logic          rst;
  logic          muao_valid;
  logic [DW-1:0] muao_data;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [31:0]   frame_cnt;
  logic [15:0]   drop_cnt;
  logic          overflow;

  mua_frame_reader #(.N_CH(N_CH), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .muao_valid (muao_valid),
    .muao_data  (muao_data),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor: records accepted words and checks stability under stall.
  logic [31:0] got_data[$];
  logic        got_last[$];
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  initial prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("stall_tdata", m_tdata, prev_data);
        check("stall_tlast", {31'd0, m_tlast}, {31'd0, prev_last});
      end
      if (m_tvalid && m_tready) begin
        got_data.push_back(m_tdata);
        got_last.push_back(m_tlast);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    muao_valid = 1'b1;
    muao_data  = d;
    tick();
    muao_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_tvalid(input string name);
    int n;
    n = 0;
    while (!m_tvalid && n < 50) begin
      tick();
      n++;
    end
    check(name, {31'd0, m_tvalid}, 32'd1);
  endtask

  task automatic clear_stream();
    got_data.delete();
    got_last.delete();
  endtask

  task automatic check_stream(input string name, input logic [31:0] exp[$]);
    int n;
    check({name, "_count"}, got_data.size(), exp.size());
    n = (got_data.size() < exp.size()) ? got_data.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", name, i), got_data[i], exp[i]);
      check($sformatf("%s_last%0d", name, i), {31'd0, got_last[i]},
            {31'd0, ((i % N_CH) == N_CH - 1)});
    end
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] din;
    logic        rdy;
    logic        exp_tvalid;
    logic [31:0] exp_tdata;
    logic        exp_tlast;
    logic [31:0] exp_fcnt;
  } vec_t;

  vec_t vt[10];
  logic [31:0] exp_q[$];
  logic [31:0] fc0;

  initial begin
    // Basic frame, one row per clock edge: inputs sampled at that edge,
    // outputs expected just after it.
    vt[0] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h0,  1'b0, 32'd0};
    vt[1] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  1'b0, 32'd0};
    vt[2] = '{1'b1, 32'h12, 1'b1, 1'b0, 32'h0,  1'b0, 32'd0};
    vt[3] = '{1'b1, 32'h13, 1'b1, 1'b0, 32'h0,  1'b0, 32'd0};
    vt[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 32'd0};
    vt[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b0, 32'd0};
    vt[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h11, 1'b0, 32'd0};
    vt[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h12, 1'b0, 32'd0};
    vt[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h13, 1'b1, 32'd0};
    vt[9] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h13, 1'b0, 32'd1};

    rst        = 1'b1;
    muao_valid = 1'b0;
    muao_data  = '0;
    m_tready   = 1'b0;
    tick();
    tick();
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // Basic frame, table driven
    for (int i = 0; i < 10; i++) begin
      muao_valid = vt[i].vld;
      muao_data  = vt[i].din;
      m_tready   = vt[i].rdy;
      tick();
      check($sformatf("basic_tvalid%0d", i), {31'd0, m_tvalid}, {31'd0, vt[i].exp_tvalid});
      if (vt[i].exp_tvalid) begin
        check($sformatf("basic_tdata%0d", i), m_tdata, vt[i].exp_tdata);
        check($sformatf("basic_tlast%0d", i), {31'd0, m_tlast}, {31'd0, vt[i].exp_tlast});
      end
      check($sformatf("basic_fcnt%0d", i), frame_cnt, vt[i].exp_fcnt);
    end
    muao_valid = 1'b0;
    check("basic_overflow", {31'd0, overflow}, 32'd0);

    // Backpressure: two frames while tready toggles every cycle
    clear_stream();
    fc0 = frame_cnt;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 50; c++) begin
        m_tready = ((c % 2) == 0);
        if (sent < 2 * N_CH) begin
          muao_valid = 1'b1;
          muao_data  = 32'h20 + 32'(sent);
          sent++;
        end else begin
          muao_valid = 1'b0;
        end
        tick();
      end
    end
    muao_valid = 1'b0;
    m_tready   = 1'b1;
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h20 + 32'(i));
    check_stream("bp", exp_q);
    check("bp_frames", frame_cnt - fc0, 32'd2);
    check("bp_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // Overflow: three frames with the consumer stalled
    clear_stream();
    m_tready = 1'b0;
    for (int i = 0; i < 3 * N_CH; i++) push_word(32'h30 + 32'(i));
    idle(3);
    check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    check("ovf_overflow", {31'd0, overflow}, 32'd1);
    m_tready = 1'b1;
    idle(20);
    for (int i = 0; i < N_CH; i++) push_word(32'h40 + 32'(i));
    idle(20);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h30 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h40 + 32'(i));
    check_stream("ovf", exp_q);
    check("ovf_drop_cnt_after", {16'd0, drop_cnt}, 32'd1);

    // Reset in the middle of a partial frame and a stalled output
    m_tready = 1'b0;
    for (int i = 0; i < N_CH; i++) push_word(32'h80 + 32'(i));
    wait_tvalid("rstmid_wait");
    push_word(32'h60);
    push_word(32'h61);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rstmid_tlast", {31'd0, m_tlast}, 32'd0);
    check("rstmid_tdata", m_tdata, 32'd0);
    check("rstmid_frame_cnt", frame_cnt, 32'd0);
    check("rstmid_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("rstmid_overflow", {31'd0, overflow}, 32'd0);
    clear_stream();
    m_tready = 1'b1;
    for (int i = 0; i < N_CH; i++) push_word(32'h70 + 32'(i));
    idle(20);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h70 + 32'(i));
    check_stream("rstmid", exp_q);
    check("rstmid_frames", frame_cnt, 32'd1);

    // Release/fill coincidence: TLAST handshake of the stalled frame lands
    // on the same edge as the last write of the next frame.
    clear_stream();
    m_tready = 1'b0;
    for (int i = 0; i < N_CH; i++) push_word(32'h90 + 32'(i));
    wait_tvalid("coin_wait");
    idle(2);
    for (int i = 0; i < N_CH; i++) begin
      m_tready   = 1'b1;
      muao_valid = 1'b1;
      muao_data  = 32'hA0 + 32'(i);
      if (i == N_CH - 1) begin
        check("coin_tlast_aligned", {31'd0, m_tvalid && m_tlast}, 32'd1);
      end
      tick();
    end
    muao_valid = 1'b0;
    for (int i = 0; i < N_CH; i++) push_word(32'hB0 + 32'(i));
    idle(25);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h90 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hB0 + 32'(i));
    check_stream("coin", exp_q);
    check("coin_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("coin_overflow", {31'd0, overflow}, 32'd0);

    // Input gaps: three idle cycles between words
    clear_stream();
    fc0 = frame_cnt;
    for (int i = 0; i < N_CH; i++) begin
      push_word(32'h50 + 32'(i));
      idle(3);
    end
    idle(10);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h50 + 32'(i));
    check_stream("gap", exp_q);
    check("gap_frames", frame_cnt - fc0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
